// File: rtl/sqrt_seq_hs_if.sv
// Handshake bundle for sqrt_seq_hs.
//   master : producer/consumer side (drives in_valid, radicand, out_ready)
//   slave  : the square-root engine (drives in_ready, out_valid, root,
//            remainder, busy)
// IN_W must match the IN_W of the engine attached to the slave modport.
interface sqrt_seq_hs_if #(
  parameter int IN_W = 24
);
  localparam int OUT_W = IN_W / 2;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  radicand;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] root;
  logic [OUT_W:0]   remainder;
  logic             busy;

  modport master (
    output in_valid, radicand, out_ready,
    input  in_ready, out_valid, root, remainder, busy
  );

  modport slave (
    input  in_valid, radicand, out_ready,
    output in_ready, out_valid, root, remainder, busy
  );
endinterface

// File: rtl/sqrt_seq_hs.sv
// Sequential integer square root, restoring digit-by-digit, one root bit
// per clock. Produces floor(sqrt(radicand)) and the exact remainder
// radicand - floor_root^2. With ROUND=1 the root is rounded to nearest
// (saturating at all ones); the remainder stays relative to the floor root.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : sqrt_seq_hs_if slave (valid/ready in, valid/ready out, busy)
// IN_W must be even and >= 2.
//
// state | meaning
// IDLE  | waiting for a radicand, in_ready=1
// CALC  | one restoring step per cycle, down-counter at zero = last step
// DONE  | result held on root/remainder until out_ready
module sqrt_seq_hs #(
  parameter int IN_W  = 24,
  parameter int ROUND = 0
) (
  input logic         clk,
  input logic         reset,
  sqrt_seq_hs_if.slave bus
);
  localparam int OUT_W = IN_W / 2;
  localparam int CNT_W = $clog2(OUT_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [IN_W-1:0]  rad_q;
  logic [OUT_W:0]   rem_q;
  logic [OUT_W-1:0] root_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             last_step;
  logic [OUT_W+1:0] rem_sh, trial, rem_step;
  logic [OUT_W-1:0] root_step, root_rnd;
  logic             ge, round_up;

  assign accept    = bus.in_valid && bus.in_ready;
  assign last_step = (state == CALC) && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: if (cnt_q == '0) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = accept ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: bus.in_ready = !reset;
      CALC: bus.busy     = 1'b1;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready && !reset;
      end
      default: ;
    endcase
  end

  // Before the final step the partial remainder is <= 2*partial_root, which
  // is below 2^OUT_W, so its top stored bit can be dropped when shifting in
  // the next radicand pair.
  always_comb begin
    rem_sh    = {rem_q[OUT_W-1:0], rad_q[IN_W-1 -: 2]};
    trial     = {root_q, 2'b01};
    ge        = (rem_sh >= trial);
    rem_step  = ge ? (rem_sh - trial) : rem_sh;
    root_step = (root_q << 1) | OUT_W'(ge);
    // Round up when radicand > r^2 + r; all-ones root has no room to grow.
    round_up  = (ROUND != 0) && (rem_step > {2'b00, root_step}) && (root_step != '1);
    root_rnd  = root_step + OUT_W'(round_up);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      rad_q  <= bus.radicand;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= CNT_W'(OUT_W - 1);
    end else if (state == CALC) begin
      rad_q  <= rad_q << 2;
      rem_q  <= rem_step[OUT_W:0];
      root_q <= last_step ? root_rnd : root_step;
      if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign bus.root      = root_q;
  assign bus.remainder = rem_q;
endmodule

// File: tb/tb_sqrt_seq_hs.sv
// Scoreboard bench for sqrt_seq_hs. Two IN_W=24 engines (ROUND=0 and
// ROUND=1) share one stimulus stream; IN_W=8 and IN_W=32 engines get a
// sweep checked against root^2 + remainder == radicand.
module tb_sqrt_seq_hs;
  logic clk = 1'b0;
  logic reset;
  logic rst_s;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  sqrt_seq_hs_if #(.IN_W(24)) if_a ();
  sqrt_seq_hs_if #(.IN_W(24)) if_b ();
  sqrt_seq_hs_if #(.IN_W(8))  if_s ();
  sqrt_seq_hs_if #(.IN_W(32)) if_l ();

  sqrt_seq_hs #(.IN_W(24), .ROUND(0)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  sqrt_seq_hs #(.IN_W(24), .ROUND(1)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
  sqrt_seq_hs #(.IN_W(8),  .ROUND(0)) dut_s (.clk(clk), .reset(rst_s), .bus(if_s.slave));
  sqrt_seq_hs #(.IN_W(32), .ROUND(0)) dut_l (.clk(clk), .reset(rst_s), .bus(if_l.slave));

  assign if_b.in_valid  = if_a.in_valid;
  assign if_b.radicand  = if_a.radicand;
  assign if_b.out_ready = if_a.out_ready;

  typedef struct {
    logic [23:0] rad;
    logic [11:0] r0;
    logic [11:0] r1;
    logic [12:0] rem;
    int          acc;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [7:0]  qs[$];
  logic [31:0] ql[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: expected event did not occur as required (t=%0t)", name, $time);
  endtask

  function automatic int unsigned isqrt(input int unsigned x);
    int unsigned r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Issue one radicand to the 24-bit pair; expectation is queued at the
  // edge where the handshake completes.
  task automatic send(input logic [23:0] r, input logic [11:0] e0,
                      input logic [11:0] e1, input logic [12:0] erem);
    exp_t e;
    bit   done = 0;
    if_a.in_valid = 1'b1;
    if_a.radicand = r;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (if_a.in_ready) begin
        e = '{r, e0, e1, erem, cyc + 1};
        qa.push_back(e);
        qb.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if_a.in_valid = 1'b0;
    if (!done) fail("send_accept");
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && (qa.size() != 0 || qb.size() != 0); n++) @(posedge clk);
    #1;
    if (qa.size() != 0 || qb.size() != 0) fail("drain");
  endtask

  // Monitor, ROUND=0 engine: latency at out_valid rise, values at handshake.
  exp_t ea, eb;
  logic prev_ova = 1'b0;
  int   last_rise = -1;
  bit   stream_on = 0;
  always @(negedge clk) begin
    if (!stream_on) last_rise = -1;
    if (if_a.out_valid && !prev_ova) begin
      if (qa.size() != 0) check("latency", 64'(cyc - qa[0].acc), 64'd12);
      if (stream_on && last_rise >= 0) check("interval", 64'(cyc - last_rise), 64'd13);
      last_rise = cyc;
    end
    prev_ova = if_a.out_valid;
    if (if_a.out_valid && if_a.out_ready) begin
      if (qa.size() == 0) fail("unexpected_out_a");
      else begin
        ea = qa.pop_front();
        check("root_floor", 64'(if_a.root), 64'(ea.r0));
        check("rem_floor", 64'(if_a.remainder), 64'(ea.rem));
      end
    end
  end

  always @(negedge clk) begin
    if (if_b.out_valid && if_b.out_ready) begin
      if (qb.size() == 0) fail("unexpected_out_b");
      else begin
        eb = qb.pop_front();
        check("root_round", 64'(if_b.root), 64'(eb.r1));
        check("rem_round", 64'(if_b.remainder), 64'(eb.rem));
      end
    end
  end

  logic [63:0] rt_s, rm_s, rt_l, rm_l;
  logic [7:0]  rad_s;
  logic [31:0] rad_l;
  always @(negedge clk) begin
    if (if_s.out_valid && if_s.out_ready) begin
      if (qs.size() == 0) fail("unexpected_out_s");
      else begin
        rad_s = qs.pop_front();
        rt_s  = 64'(if_s.root);
        rm_s  = 64'(if_s.remainder);
        check("identity_w8", rt_s * rt_s + rm_s, 64'(rad_s));
        check("rembound_w8", 64'(rm_s <= 2 * rt_s), 64'd1);
      end
    end
    if (if_l.out_valid && if_l.out_ready) begin
      if (ql.size() == 0) fail("unexpected_out_l");
      else begin
        rad_l = ql.pop_front();
        rt_l  = 64'(if_l.root);
        rm_l  = 64'(if_l.remainder);
        check("identity_w32", rt_l * rt_l + rm_l, 64'(rad_l));
        check("rembound_w32", 64'(rm_l <= 2 * rt_l), 64'd1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_bad + 1);
    $fatal(1);
  end

  logic [7:0]  v_s;
  logic [31:0] v_l;
  bit          ok_s, ok_l;
  int unsigned fr, frem, rr;

  initial begin
    reset = 1'b1;
    rst_s = 1'b1;
    if_a.in_valid  = 1'b0;
    if_a.radicand  = '0;
    if_a.out_ready = 1'b1;
    if_s.in_valid  = 1'b0;
    if_s.radicand  = '0;
    if_s.out_ready = 1'b1;
    if_l.in_valid  = 1'b0;
    if_l.radicand  = '0;
    if_l.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(if_a.out_valid), 64'd0);
    check("rst_busy", 64'(if_a.busy), 64'd0);
    check("rst_in_ready", 64'(if_a.in_ready), 64'd0);
    check("rst_root", 64'(if_a.root), 64'd0);
    check("rst_rem", 64'(if_a.remainder), 64'd0);
    check("rst_out_valid_b", 64'(if_b.out_valid), 64'd0);
    reset = 1'b0;
    rst_s = 1'b0;
    @(posedge clk);
    #1;
    check("idle_in_ready", 64'(if_a.in_ready), 64'd1);

    // Basic values, ROUND comparison, saturation
    send(24'd0,        12'd0,    12'd0,    13'd0);
    send(24'd4194304,  12'd2048, 12'd2048, 13'd0);
    send(24'd16777215, 12'd4095, 12'd4095, 13'd8190);
    send(24'd200,      12'd14,   12'd14,   13'd4);
    send(24'd210,      12'd14,   12'd14,   13'd14);
    send(24'd211,      12'd14,   12'd15,   13'd15);
    drain();

    // Backpressure: hold DONE five cycles with a competing in_valid
    if_a.out_ready = 1'b0;
    send(24'd1000, 12'd31, 12'd32, 13'd39);
    ok_s = 0;
    for (int n = 0; n < 50 && !ok_s; n++) begin
      @(negedge clk);
      if (if_a.out_valid) ok_s = 1;
    end
    if (!ok_s) fail("bp_out_valid_wait");
    @(posedge clk);
    #1;
    if_a.in_valid = 1'b1;
    if_a.radicand = 24'd999;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", 64'(if_a.out_valid), 64'd1);
      check("bp_root", 64'(if_a.root), 64'd31);
      check("bp_rem", 64'(if_a.remainder), 64'd39);
      check("bp_in_ready", 64'(if_a.in_ready), 64'd0);
      check("bp_root_round", 64'(if_b.root), 64'd32);
    end
    @(posedge clk);
    #1;
    if_a.in_valid  = 1'b0;
    if_a.out_ready = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_extra_accept", 64'(if_a.in_ready), 64'd1);
    check("bp_no_extra_busy", 64'(if_a.busy), 64'd0);

    // Streaming 1..100
    stream_on = 1;
    for (int i = 1; i <= 100; i++) begin
      fr   = isqrt(i);
      frem = i - fr * fr;
      rr   = (frem > fr) ? fr + 1 : fr;
      send(24'(i), 12'(fr), 12'(rr), 13'(frem));
    end
    drain();
    stream_on = 0;

    // Reset during the 6th CALC cycle aborts the operation
    send(24'd1000, 12'd31, 12'd32, 13'd39);
    repeat (5) @(posedge clk);
    #1;
    check("calc_busy", 64'(if_a.busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    qa.delete();
    qb.delete();
    check("abort_busy", 64'(if_a.busy), 64'd0);
    check("abort_out_valid", 64'(if_a.out_valid), 64'd0);
    check("abort_root", 64'(if_a.root), 64'd0);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_idle", 64'(if_a.in_ready), 64'd1);
    check("abort_no_stale", 64'(if_a.out_valid), 64'd0);
    send(24'd123456, 12'd351, 12'd351, 13'd255);
    drain();

    // Width sweep on the 8- and 32-bit engines
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          v_s = (i == 0) ? 8'd0 : (i == 1) ? 8'hFF : 8'($urandom);
          if_s.in_valid = 1'b1;
          if_s.radicand = v_s;
          ok_s = 0;
          for (int n = 0; n < 100 && !ok_s; n++) begin
            @(negedge clk);
            if (if_s.in_ready) begin
              qs.push_back(v_s);
              ok_s = 1;
            end
            @(posedge clk);
            #1;
          end
          if (!ok_s) fail("send_accept_w8");
        end
        if_s.in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          v_l = (i == 0) ? 32'd0 : (i == 1) ? 32'hFFFF_FFFF : $urandom;
          if_l.in_valid = 1'b1;
          if_l.radicand = v_l;
          ok_l = 0;
          for (int n = 0; n < 100 && !ok_l; n++) begin
            @(negedge clk);
            if (if_l.in_ready) begin
              ql.push_back(v_l);
              ok_l = 1;
            end
            @(posedge clk);
            #1;
          end
          if (!ok_l) fail("send_accept_w32");
        end
        if_l.in_valid = 1'b0;
      end
    join

    repeat (40) @(posedge clk);
    #1;
    check("queue_a_empty", 64'(qa.size()), 64'd0);
    check("queue_b_empty", 64'(qb.size()), 64'd0);
    check("queue_s_empty", 64'(qs.size()), 64'd0);
    check("queue_l_empty", 64'(ql.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
